challenge_sequencer: RTL and testbench
======================================

CHALLENGE_SEQUENCER -- requirements
Module: challenge_sequencer

Interface
REQ-001 Parameter CHALL_W, default 8, SHALL set the challenge width.
REQ-002 Parameter CNT_W, default 8, SHALL set the challenge-count width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 start  input  1  SHALL request one run; sampled only in IDLE.
REQ-006 seed  input  CHALL_W  SHALL give the initial challenge; captured when start is accepted.
REQ-007 num_chall  input  CNT_W  SHALL give the number of challenges to emit; captured when start is accepted.
REQ-008 scr_chall_in  output  CHALL_W  SHALL drive the scrambler seed input.
REQ-009 scr_reset  output  1  SHALL drive the scrambler reset.
REQ-010 scr_increment  output  1  SHALL drive the scrambler advance pulse.
REQ-011 scr_chall_out  input  CHALL_W  SHALL carry the scrambler's current challenge.
REQ-012 chall_valid  output  1  SHALL flag chall_data as valid.
REQ-013 chall_data  output  CHALL_W  SHALL carry the captured challenge.
REQ-014 chall_ready  input  1  SHALL accept chall_data when high together with chall_valid.
REQ-015 busy  output  1  SHALL be high in every state except IDLE.
REQ-016 done  output  1  SHALL pulse high for one cycle at the end of a run.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, SETTLE, EMIT, STEP, WAIT and DONE; all outputs SHALL be registered.
REQ-018 IDLE->LOAD when start=1; seed and num_chall SHALL be registered, and the remaining count SHALL load num_chall.
REQ-019 If num_chall=0 at start, IDLE->DONE SHALL occur directly, with no scr_reset, no scr_increment and no chall_valid.
REQ-020 LOAD: scr_reset=1 for exactly one cycle, with scr_chall_in=seed; then SETTLE for one cycle; then EMIT.
REQ-021 On entry to EMIT, chall_data SHALL capture scr_chall_out, and chall_valid SHALL be 1.
REQ-022 While chall_valid=1 and chall_ready=0, chall_data SHALL hold stable, with no scrambler activity.
REQ-023 On a handshake (chall_valid & chall_ready), chall_valid SHALL drop the next cycle and the count SHALL decrement.
  - If the count becomes 0: EMIT->DONE.
  - Otherwise: EMIT->STEP.
REQ-024 STEP: scr_increment=1 for exactly one cycle; then WAIT for one cycle; then EMIT.
REQ-025 DONE: done=1 for one cycle, then IDLE; busy SHALL drop on the cycle IDLE is entered.
REQ-026 Latency:
  - start sampled at edge k -> scr_reset high during cycle k+1.
  - First chall_valid SHALL be high from edge k+3.
  - With chall_ready tied high, successive chall_valid SHALL be 3 cycles apart.
REQ-027 start while busy SHALL be ignored; a new run SHALL be accepted on the cycle following DONE, once back in IDLE.
REQ-028 scr_chall_in SHALL hold the captured seed throughout the run and in IDLE.
REQ-029 Exactly num_chall handshakes and num_chall-1 scr_increment pulses SHALL occur per run.
  - num_chall=2^CNT_W-1 SHALL work without overflow.

Reset
REQ-030 reset=1 SHALL force IDLE, count=0, and the following output values: chall_valid=0, chall_data=0, scr_chall_in=0, scr_reset=0, scr_increment=0, busy=0, done=0.
REQ-031 reset mid-run SHALL abort the run on the next edge, with no done pulse; an in-flight chall_valid SHALL drop without a handshake.
REQ-032 reset SHALL take priority over start and chall_ready in the same cycle.

Structure
REQ-033 Package challenge_seq_pkg SHALL hold the FSM state enum and the default CHALL_W/CNT_W constants.
REQ-034 No sub-module SHALL be used; scrambler_lfsr SHALL be instantiated beside this block at the top level, not inside it.

Verification
REQ-035 Seed=8'h02, num_chall=8, chall_ready=1:
  - one scr_reset pulse; 7 scr_increment pulses; 8 handshakes.
  - chall_data matches the scrambler reference model sequence.
  - done one cycle after the 8th handshake.
REQ-036 num_chall=0 -> done 1 cycle after start; zero scr_reset, scr_increment and chall_valid.
REQ-037 Ready stalls: chall_ready=0 for 5 cycles on the 2nd challenge -> chall_data stable, no scr_increment during the stall, count unchanged.
REQ-038 reset asserted while in WAIT on a num_chall=4 run -> next cycle IDLE, all outputs 0, no done pulse; a following start runs cleanly.
REQ-039 start pulsed while busy -> ignored, with seed/num_chall unchanged; start on the cycle after DONE -> new run begins.
REQ-040 Latency check with num_chall=1:
  - start at edge k -> scr_reset during k+1.
  - chall_valid at k+3.
  - done one cycle after the handshake.
  - zero scr_increment pulses.

Source files
------------

// File: rtl/challenge_seq_pkg.sv
// challenge_seq_pkg: shared state encoding and default widths for challenge_sequencer
package challenge_seq_pkg;
  localparam int CHALL_W_DEF = 8;
  localparam int CNT_W_DEF = 8;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, EMIT, STEP, WAIT, DONE} state_t;
endpackage

// File: rtl/challenge_sequencer.sv
// challenge_sequencer: drives an external scrambler and streams num_chall challenges over a valid/ready port
module challenge_sequencer
  import challenge_seq_pkg::*;
#(
  parameter int CHALL_W = CHALL_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CHALL_W-1:0] seed,
  input  logic [CNT_W-1:0]   num_chall,
  output logic [CHALL_W-1:0] scr_chall_in,
  output logic               scr_reset,
  output logic               scr_increment,
  input  logic [CHALL_W-1:0] scr_chall_out,
  output logic               chall_valid,
  output logic [CHALL_W-1:0] chall_data,
  input  logic               chall_ready,
  output logic               busy,
  output logic               done
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CHALL_W-1:0] seed_q, seed_d, data_q, data_d;
  logic rst_q, rst_d, inc_q, inc_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    seed_d = seed_q;
    case (state_q)
      IDLE: if (start) begin
        seed_d = seed;
        cnt_d = num_chall;
        state_d = (num_chall == '0) ? DONE : LOAD;
      end
      LOAD: state_d = SETTLE;
      SETTLE: state_d = EMIT;
      EMIT: if (valid_q && chall_ready) begin
        cnt_d = cnt_q - CNT_W'(1);
        state_d = (cnt_q == CNT_W'(1)) ? DONE : STEP;
      end
      STEP: state_d = WAIT;
      WAIT: state_d = EMIT;
      default: state_d = IDLE;
    endcase
    data_d = (state_d == EMIT && state_q != EMIT) ? scr_chall_out : data_q;
    rst_d = state_d == LOAD;
    inc_d = state_d == STEP;
    valid_d = state_d == EMIT;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      seed_q <= '0;
      data_q <= '0;
      rst_q <= 1'b0;
      inc_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      seed_q <= seed_d;
      data_q <= data_d;
      rst_q <= rst_d;
      inc_q <= inc_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign scr_chall_in = seed_q;
  assign scr_reset = rst_q;
  assign scr_increment = inc_q;
  assign chall_valid = valid_q;
  assign chall_data = data_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_challenge_sequencer.sv
// tb_challenge_sequencer: table, random and corner-case checks of challenge_sequencer against an LFSR scrambler model
module tb_challenge_sequencer;
  logic clk = 1'b0, reset, start, chall_ready;
  logic [7:0] seed, num_chall, scr_chall_in, scr_chall_out, chall_data, lfsr;
  logic scr_reset, scr_increment, chall_valid, busy, done;
  int tests = 0, fails = 0, cyc = 0, c0 = 0;
  int n_rst, n_inc, n_hs, n_done, stall_bad, first_rst, first_valid, done_cyc, last_hs;
  logic [7:0] got[$];
  typedef struct {
    logic [7:0] s;
    logic [7:0] n;
    int rst, inc, hs, len;
  } vec_t;
  vec_t tbl[6];
  challenge_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .num_chall(num_chall),
    .scr_chall_in(scr_chall_in), .scr_reset(scr_reset), .scr_increment(scr_increment),
    .scr_chall_out(scr_chall_out), .chall_valid(chall_valid), .chall_data(chall_data),
    .chall_ready(chall_ready), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] nxt(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction
  always_ff @(posedge clk)
    if (scr_reset) lfsr <= scr_chall_in;
    else if (scr_increment) lfsr <= nxt(lfsr);
  assign scr_chall_out = lfsr;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic clr();
    n_rst = 0; n_inc = 0; n_hs = 0; n_done = 0; stall_bad = 0;
    first_rst = -1; first_valid = -1; done_cyc = -1; last_hs = -1;
    got.delete();
  endtask
  task automatic step();
    bit hs, stl;
    logic [7:0] d;
    hs = chall_valid && chall_ready;
    stl = chall_valid && !chall_ready;
    d = chall_data;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin got.push_back(d); n_hs++; last_hs = cyc; end
    if (stl && (!chall_valid || chall_data !== d || scr_increment)) stall_bad++;
    if (scr_reset) begin n_rst++; if (first_rst < 0) first_rst = cyc; end
    if (scr_increment) n_inc++;
    if (chall_valid && first_valid < 0) first_valid = cyc;
    if (done) begin n_done++; done_cyc = cyc; end
  endtask
  task automatic run(input logic [7:0] s, input logic [7:0] n, input int mode);
    int stall = 0, bad = 0;
    logic [7:0] v;
    clr();
    seed = s; num_chall = n; start = 1'b1; chall_ready = 1'b1;
    step();
    start = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 3000 && n_done == 0; i++) begin
      if (mode == 3 && i == 2) begin start = 1'b1; seed = 8'h77; num_chall = 8'd9; end
      else start = 1'b0;
      chall_ready = (mode == 1) ? 1'($urandom_range(0, 1)) :
                    (mode == 2 && n_hs == 1 && chall_valid && stall < 5) ? 1'b0 : 1'b1;
      if (mode == 2 && !chall_ready) stall++;
      step();
    end
    start = 1'b0;
    chk("run_done_pulse", n_done, 1);
    if (n != 0) chk("done_after_last_hs", done_cyc - last_hs, 0);
    chk("stall_stable", stall_bad, 0);
    chk("data_count", got.size(), n);
    v = s;
    foreach (got[i]) begin
      if (got[i] !== v) bad++;
      v = nxt(v);
    end
    chk("data_sequence", bad, 0);
    chall_ready = 1'b1;
    step();
    chk("idle_after_done", {busy, done, chall_valid}, 0);
  endtask
  initial begin
    tbl[0] = '{8'h02, 8'd8, 1, 7, 8, 24};
    tbl[1] = '{8'h02, 8'd1, 1, 0, 1, 3};
    tbl[2] = '{8'hA5, 8'd0, 0, 0, 0, 0};
    tbl[3] = '{8'hFF, 8'd3, 1, 2, 3, 9};
    tbl[4] = '{8'h01, 8'd2, 1, 1, 2, 6};
    tbl[5] = '{8'h55, 8'd255, 1, 254, 255, 765};
    reset = 1'b1; start = 1'b1; chall_ready = 1'b1; seed = 8'hAA; num_chall = 8'd5;
    step();
    step();
    chk("reset_outputs", {chall_valid, chall_data, scr_chall_in, scr_reset, scr_increment, busy, done}, 0);
    reset = 1'b0; start = 1'b0;
    step();
    chk("idle_no_start", busy, 0);
    foreach (tbl[i]) begin
      run(tbl[i].s, tbl[i].n, 0);
      chk("tbl_scr_reset", n_rst, tbl[i].rst);
      chk("tbl_scr_increment", n_inc, tbl[i].inc);
      chk("tbl_handshakes", n_hs, tbl[i].hs);
      chk("tbl_run_length", done_cyc - c0, tbl[i].len);
      if (tbl[i].n != 0) begin
        chk("lat_scr_reset", first_rst - c0, 0);
        chk("lat_first_valid", first_valid - c0, 2);
      end else chk("zero_no_valid", first_valid, -1);
    end
    run(8'h02, 8'd4, 2);
    chk("stall_handshakes", n_hs, 4);
    chk("stall_increments", n_inc, 3);
    chk("stall_length", done_cyc - c0, 17);
    clr();
    seed = 8'h10; num_chall = 8'd4; start = 1'b1; chall_ready = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("wait_prev_step_inc", scr_increment, 1);
    step();
    chk("in_wait", {busy, scr_increment, chall_valid}, 3'b100);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_in_wait_outputs", {chall_valid, chall_data, scr_chall_in, scr_reset, scr_increment, busy, done}, 0);
    step(); step();
    chk("reset_in_wait_no_done", n_done, 0);
    chk("reset_in_wait_idle", {busy, chall_valid}, 0);
    run(8'h33, 8'd2, 0);
    chk("after_reset_handshakes", n_hs, 2);
    chk("after_reset_length", done_cyc - c0, 6);
    run(8'h02, 8'd3, 3);
    chk("busy_start_handshakes", n_hs, 3);
    chk("busy_start_seed_held", scr_chall_in, 8'h02);
    run(8'h5A, 8'd2, 0);
    chk("restart_handshakes", n_hs, 2);
    chk("restart_length", done_cyc - c0, 6);
    for (int r = 0; r < 20; r++) begin
      logic [7:0] s, n;
      s = 8'($urandom);
      n = 8'($urandom_range(0, 12));
      run(s, n, 1);
      chk("rnd_handshakes", n_hs, n);
      chk("rnd_increments", n_inc, (n == 0) ? 0 : n - 1);
      chk("rnd_scr_reset", n_rst, (n != 0) ? 1 : 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
